// File: rtl/fp_mul_ctrl.sv
// fp_mul_ctrl: binary32 multiply controller in front of the booth mantissa multiplier.
// Unpacks/classifies two operands, resolves specials locally, otherwise issues one
// 24x24 mantissa multiply (BREQ/m1/m2), captures the 48-bit product on BACK, then
// normalises, rounds to nearest-even (flush-to-zero) and packs the result.
// Ports:
//   CLK, RSTK          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  operand handshake; in_ready is high only while idle
//   opa, opb           binary32 operands
//   out_valid          one-cycle pulse, result/flags valid (held until next result)
//   result, flags      product and {timeout, invalid, overflow, underflow, inexact}
//   BREQ, m1, m2       booth start pulse and mantissas with hidden bit
//   BACK, res          booth done pulse and 48-bit product (valid in the BACK cycle)
module fp_mul_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [31:0] QNAN    = 32'h7FC0_0000
) (
  input  logic        CLK,
  input  logic        RSTK,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [4:0]  flags,
  output logic        BREQ,
  output logic [23:0] m1,
  output logic [23:0] m2,
  input  logic        BACK,
  input  logic [47:0] res
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned EW = 10;
  localparam int unsigned MW = 24;
  localparam int unsigned PW = 48;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_MUL_REQ, S_MUL_WAIT, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t                state, state_n;
  logic [31:0]           op_a, op_a_n, op_b, op_b_n;
  logic                  sign, sign_n;
  logic signed [EW-1:0]  e, e_n;
  logic [PW-1:0]         prod, prod_n;
  logic [22:0]           mant, mant_n;
  logic                  guard, guard_n, sticky, sticky_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [31:0]           pend_result, pend_result_n;
  logic [4:0]            pend_flags, pend_flags_n;
  logic [31:0]           result_n;
  logic [4:0]            flags_n;
  logic                  out_valid_n, in_ready_n, breq_n;
  logic [MW-1:0]         m1_n, m2_n;

  // Operand classification (denormals count as zero)
  logic [7:0] ea, eb;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign ea     = op_a[30:23];
  assign eb     = op_b[30:23];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (op_a[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (op_b[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (op_a[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (op_b[22:0] != 23'd0);

  // Rounding datapath
  logic                 inc;
  logic [MW-1:0]        mant_sum;
  logic signed [EW-1:0] e_r;
  logic                 inexact;

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    op_a_n        = op_a;
    op_b_n        = op_b;
    sign_n        = sign;
    e_n           = e;
    prod_n        = prod;
    mant_n        = mant;
    guard_n       = guard;
    sticky_n      = sticky;
    cnt_n         = cnt;
    pend_result_n = pend_result;
    pend_flags_n  = pend_flags;
    result_n      = result;
    flags_n       = flags;
    out_valid_n   = 1'b0;
    breq_n        = 1'b0;
    m1_n          = m1;
    m2_n          = m2;
    inc           = guard & (sticky | mant[0]);
    mant_sum      = {1'b0, mant} + MW'(inc);
    e_r           = e + (mant_sum[23] ? EW'(1) : EW'(0));
    inexact       = guard | sticky;

    unique case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          op_a_n  = opa;
          op_b_n  = opb;
          state_n = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_n = op_a[31] ^ op_b[31];
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
          pend_result_n = QNAN;
          pend_flags_n  = 5'b01000;
          state_n       = S_DONE;
        end else if (a_inf || b_inf) begin
          pend_result_n = {op_a[31] ^ op_b[31], 8'hFF, 23'd0};
          pend_flags_n  = 5'b00000;
          state_n       = S_DONE;
        end else if (a_zero || b_zero) begin
          pend_result_n = {op_a[31] ^ op_b[31], 31'd0};
          pend_flags_n  = 5'b00000;
          state_n       = S_DONE;
        end else begin
          m1_n    = {1'b1, op_a[22:0]};
          m2_n    = {1'b1, op_b[22:0]};
          e_n     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - EW'(127);
          breq_n  = 1'b1;
          cnt_n   = '0;
          state_n = S_MUL_REQ;
        end
      end
      S_MUL_REQ: begin
        cnt_n   = '0;
        state_n = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        // A BACK coinciding with the last wait cycle still wins
        if (BACK) begin
          prod_n  = res;
          state_n = S_NORM;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          pend_result_n = QNAN;
          pend_flags_n  = 5'b10000;
          state_n       = S_DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_NORM: begin
        if (prod[47]) begin
          mant_n   = prod[46:24];
          guard_n  = prod[23];
          sticky_n = |prod[22:0];
          e_n      = e + EW'(1);
        end else begin
          mant_n   = prod[45:23];
          guard_n  = prod[22];
          sticky_n = |prod[21:0];
        end
        state_n = S_ROUND;
      end
      S_ROUND: begin
        if (e_r >= EW'(255)) begin
          pend_result_n = {sign, 8'hFF, 23'd0};
          pend_flags_n  = 5'b00101;
        end else if (e_r <= EW'(0)) begin
          pend_result_n = {sign, 31'd0};
          pend_flags_n  = 5'b00011;
        end else begin
          pend_result_n = {sign, e_r[7:0], mant_sum[22:0]};
          pend_flags_n  = {4'b0000, inexact};
        end
        state_n = S_DONE;
      end
      S_DONE: begin
        result_n    = pend_result;
        flags_n     = pend_flags;
        out_valid_n = 1'b1;
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    in_ready_n = (state_n == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RSTK) begin
    if (!RSTK) begin
      state       <= S_IDLE;
      op_a        <= '0;
      op_b        <= '0;
      sign        <= 1'b0;
      e           <= '0;
      prod        <= '0;
      mant        <= '0;
      guard       <= 1'b0;
      sticky      <= 1'b0;
      cnt         <= '0;
      pend_result <= '0;
      pend_flags  <= '0;
      result      <= '0;
      flags       <= '0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      BREQ        <= 1'b0;
      m1          <= '0;
      m2          <= '0;
    end else begin
      state       <= state_n;
      op_a        <= op_a_n;
      op_b        <= op_b_n;
      sign        <= sign_n;
      e           <= e_n;
      prod        <= prod_n;
      mant        <= mant_n;
      guard       <= guard_n;
      sticky      <= sticky_n;
      cnt         <= cnt_n;
      pend_result <= pend_result_n;
      pend_flags  <= pend_flags_n;
      result      <= result_n;
      flags       <= flags_n;
      out_valid   <= out_valid_n;
      in_ready    <= in_ready_n;
      BREQ        <= breq_n;
      m1          <= m1_n;
      m2          <= m2_n;
    end
  end

endmodule

// File: tb/tb_fp_mul_ctrl.sv
// tb_fp_mul_ctrl: directed bench for fp_mul_ctrl with a behavioural booth responder.
module tb_fp_mul_ctrl;

  logic        CLK = 1'b0;
  logic        RSTK;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] opa, opb;
  logic        out_valid;
  logic [31:0] result;
  logic [4:0]  flags;
  logic        BREQ;
  logic [23:0] m1, m2;
  logic        BACK;
  logic [47:0] res;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  fp_mul_ctrl #(.TIMEOUT(64), .QNAN(32'h7FC0_0000)) dut (
    .CLK(CLK), .RSTK(RSTK), .in_valid(in_valid), .in_ready(in_ready),
    .opa(opa), .opb(opb), .out_valid(out_valid), .result(result), .flags(flags),
    .BREQ(BREQ), .m1(m1), .m2(m2), .BACK(BACK), .res(res)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and act as booth; dly = negedges after BREQ before BACK is driven
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit with_back,
                        input int dly, input bit poke,
                        output logic [31:0] r, output logic [4:0] f, output bit seen,
                        output int n_breq, output logic [23:0] c1, output logic [23:0] c2,
                        output int t_acc, output int t_back, output int t_ov, output int t_breq,
                        output logic busy_rdy, output logic ov_after);
    seen = 0; n_breq = 0; c1 = '0; c2 = '0; r = '0; f = '0;
    t_back = -1; t_ov = -1; t_breq = -1; busy_rdy = 1'b1;
    @(negedge CLK);
    opa = a; opb = b; in_valid = 1'b1;
    @(negedge CLK);
    t_acc = cyc; in_valid = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      BACK = 1'b0; res = '0; in_valid = 1'b0;
      if (BREQ) begin n_breq++; t_breq = cyc; c1 = m1; c2 = m2; end
      if (out_valid) begin
        seen = 1; t_ov = cyc; r = result; f = flags;
      end else begin
        if (with_back && t_breq >= 0 && t_back < 0 && cyc == t_breq + dly) begin
          BACK = 1'b1; res = 48'(m1) * 48'(m2); t_back = cyc + 1;
        end
        if (poke && t_breq >= 0 && cyc == t_breq + 1) begin
          in_valid = 1'b1; opa = 32'h4000_0000; opb = 32'h4000_0000; busy_rdy = in_ready;
        end
        @(negedge CLK);
      end
    end
    BACK = 1'b0; in_valid = 1'b0;
    @(negedge CLK);
    ov_after = out_valid;
  endtask

  logic [31:0] r;
  logic [4:0]  f;
  bit          seen;
  int          nb, ta, tb, to, tr;
  logic [23:0] c1, c2;
  logic        brdy, ova;
  bit          any_ov;

  task automatic check_result(input string tag, input logic [31:0] er, input logic [4:0] ef);
    chk({tag, "_seen"}, 48'(seen), 48'd1);
    chk({tag, "_result"}, 48'(r), 48'(er));
    chk({tag, "_flags"}, 48'(f), 48'(ef));
    chk({tag, "_pulse"}, 48'(ova), 48'd0);
  endtask

  initial begin
    RSTK = 1'b0; in_valid = 1'b0; BACK = 1'b0; res = '0; opa = '0; opb = '0;
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", 48'(in_ready), 48'd1);
    chk("rst_out_valid", 48'(out_valid), 48'd0);
    chk("rst_result", 48'(result), 48'd0);
    chk("rst_flags", 48'(flags), 48'd0);
    chk("rst_breq", 48'(BREQ), 48'd0);
    chk("rst_m1m2", {m1, m2}, 48'd0);
    RSTK = 1'b1;
    @(negedge CLK);

    // BACK while idle is ignored
    BACK = 1'b1; res = 48'h1234_5678_9ABC;
    @(negedge CLK);
    BACK = 1'b0; res = '0;
    @(negedge CLK);
    chk("idle_back_ov", 48'(out_valid), 48'd0);
    chk("idle_back_rdy", 48'(in_ready), 48'd1);

    // 1.5 * 2 = 3
    run_op(32'h3FC0_0000, 32'h4000_0000, 1, 2, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("t1", 32'h4040_0000, 5'b00000);
    chk("t1_breq_cnt", 48'(nb), 48'd1);
    chk("t1_m1", 48'(c1), 48'hC0_0000);
    chk("t1_m2", 48'(c2), 48'h80_0000);
    chk("t1_latency", 48'(to - tb), 48'd3);

    // inf * 0 -> invalid, bypass
    run_op(32'h7F80_0000, 32'h0000_0000, 1, 2, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("t2", 32'h7FC0_0000, 5'b01000);
    chk("t2_breq_cnt", 48'(nb), 48'd0);
    chk("t2_latency", 48'(to - ta), 48'd2);

    // NaN operand
    run_op(32'h7F80_0001, 32'h3F80_0000, 1, 2, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("nan", 32'h7FC0_0000, 5'b01000);

    // -inf * 2 -> -inf
    run_op(32'hFF80_0000, 32'h4000_0000, 1, 2, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("inf_fin", 32'hFF80_0000, 5'b00000);
    chk("inf_fin_breq", 48'(nb), 48'd0);

    // denormal * -3 -> -0
    run_op(32'h0000_0001, 32'hC040_0000, 1, 2, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("zero_fin", 32'h8000_0000, 5'b00000);

    // overflow
    run_op(32'h7F7F_FFFF, 32'h4000_0000, 1, 1, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("t3", 32'h7F80_0000, 5'b00101);

    // sticky only, no round up
    run_op(32'h3F80_0001, 32'h3F80_0001, 1, 3, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("t4a", 32'h3F80_0002, 5'b00001);

    // underflow flushes to zero
    run_op(32'h0080_0000, 32'h0080_0000, 1, 1, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("t4b", 32'h0000_0000, 5'b00011);

    // -2 * 3, plus a busy-time request that must be refused
    run_op(32'hC000_0000, 32'h4040_0000, 1, 3, 1, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("neg", 32'hC0C0_0000, 5'b00000);
    chk("busy_in_ready", 48'(brdy), 48'd0);
    any_ov = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (out_valid || BREQ) any_ov = 1;
    end
    chk("busy_not_accepted", 48'(any_ov), 48'd0);

    // product >= 2 path: 1.5 * 1.5 = 2.25
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 1, 1, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("p47", 32'h4010_0000, 5'b00000);

    // tie, odd lsb -> round up
    run_op(32'h3F80_0001, 32'h3FC0_0000, 1, 2, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("tie_up", 32'h3FC0_0002, 5'b00001);

    // tie, even lsb -> stays
    run_op(32'h3F80_0003, 32'h3FC0_0000, 1, 2, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("tie_even", 32'h3FC0_0004, 5'b00001);

    // (2-ulp)^2
    run_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 1, 2, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("max_mant", 32'h407F_FFFE, 5'b00001);

    // booth never answers -> timeout
    run_op(32'h4000_0000, 32'h4000_0000, 0, 0, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("t5", 32'h7FC0_0000, 5'b10000);
    chk("t5_wait", 48'(to - tr), 48'd66);

    run_op(32'h3FC0_0000, 32'h4000_0000, 1, 1, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("t5_next", 32'h4040_0000, 5'b00000);

    // reset during MUL_WAIT with a request pending while busy
    @(negedge CLK);
    opa = 32'h4000_0000; opb = 32'h4040_0000; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (BREQ) seen = 1;
      @(negedge CLK);
    end
    chk("t6_breq_seen", 48'(seen), 48'd1);
    @(negedge CLK);
    opa = 32'h3F80_0000; opb = 32'h3F80_0000; in_valid = 1'b1;
    chk("t6_busy_rdy", 48'(in_ready), 48'd0);
    RSTK = 1'b0;
    #1;
    chk("t6_rst_ov", 48'(out_valid), 48'd0);
    chk("t6_rst_result", 48'(result), 48'd0);
    chk("t6_rst_flags", 48'(flags), 48'd0);
    chk("t6_rst_breq", 48'(BREQ), 48'd0);
    chk("t6_rst_m", {m1, m2}, 48'd0);
    chk("t6_rst_rdy", 48'(in_ready), 48'd1);
    @(negedge CLK);
    in_valid = 1'b0;
    RSTK = 1'b1;
    @(negedge CLK);
    chk("t6_rel_rdy", 48'(in_ready), 48'd1);
    any_ov = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid || BREQ || !in_ready) any_ov = 1;
      @(negedge CLK);
    end
    chk("t6_quiet", 48'(any_ov), 48'd0);

    run_op(32'h3FC0_0000, 32'h4000_0000, 1, 2, 0, r, f, seen, nb, c1, c2, ta, tb, to, tr, brdy, ova);
    check_result("t6_next", 32'h4040_0000, 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
